// File: rtl/wb_pkg.sv
// Shared constants and helpers for the multi-lane writeback stage.
package wb_pkg;

    localparam logic [1:0] LS_BYTE   = 2'd0;
    localparam logic [1:0] LS_HALF   = 2'd1;
    localparam logic [1:0] LS_WORD   = 2'd2;
    localparam int         MAX_LANES = 4;

    function automatic logic [2:0] popcount(input logic [MAX_LANES-1:0] bits);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            n = n + 3'(bits[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/wb_load_align.sv
// Extracts a byte/half/word from the low 32 bits of a memory word and
// extends it to DATA_W bits.
module wb_load_align
    import wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [31:0]       raw,
    input  logic [1:0]        size,
    input  logic              sign,
    input  logic [1:0]        offset,
    output logic [DATA_W-1:0] value
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] ext32;

    always_comb begin
        byte_val = 8'(raw >> {offset, 3'b000});
        // Halfword loads ignore the low offset bit.
        half_val = offset[1] ? raw[31:16] : raw[15:0];
        case (size)
            LS_BYTE: ext32 = {{24{sign & byte_val[7]}}, byte_val};
            LS_HALF: ext32 = {{16{sign & half_val[15]}}, half_val};
            default: ext32 = raw;
        endcase
    end

    generate
        if (DATA_W > 32) begin : g_wide
            assign value = {{(DATA_W-32){sign & ext32[31]}}, ext32};
        end else begin : g_narrow
            assign value = ext32;
        end
    endgenerate

endmodule

// File: rtl/wb_stage_multi.sv
// Multi-lane writeback stage: lane data select, same-destination priority,
// r0 suppression, registered register-file write ports and a retire counter.
module wb_stage_multi
    import wb_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic                     clock2,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES-1:0]         in_wb_en,
    input  logic [LANES-1:0]         in_mem_read,
    input  logic [2*LANES-1:0]       in_load_size,
    input  logic [LANES-1:0]         in_load_signed,
    input  logic [2*LANES-1:0]       in_byte_off,
    input  logic [REG_AW*LANES-1:0] in_dest,
    input  logic [DATA_W*LANES-1:0] in_alu_result,
    input  logic [DATA_W*LANES-1:0] in_mem_data,
    output logic [LANES-1:0]         rf_we,
    output logic [REG_AW*LANES-1:0] rf_waddr,
    output logic [DATA_W*LANES-1:0] rf_wdata,
    input  logic                     rf_ready,
    output logic [31:0]              retired_count
);

    logic                      held;
    logic                      accept;
    logic                      commit;
    logic [LANES-1:0]          en_raw;
    logic [LANES-1:0]          en_final;
    logic [LANES*LANES-1:0]    kill;
    logic [DATA_W*LANES-1:0]   lane_data;
    logic [DATA_W*LANES-1:0]   aligned;
    logic [31:0]               retire_inc;

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            wb_load_align #(.DATA_W(DATA_W)) u_align (
                .raw    (in_mem_data[k*DATA_W +: 32]),
                .size   (in_load_size[2*k +: 2]),
                .sign   (in_load_signed[k]),
                .offset (in_byte_off[2*k +: 2]),
                .value  (aligned[k*DATA_W +: DATA_W])
            );

            assign lane_data[k*DATA_W +: DATA_W] = in_mem_read[k]
                ? aligned[k*DATA_W +: DATA_W]
                : in_alu_result[k*DATA_W +: DATA_W];

            assign en_raw[k] = in_wb_en[k] && (in_dest[k*REG_AW +: REG_AW] != '0);

            // A higher lane writing the same register squashes this lane.
            for (genvar j = 0; j < LANES; j++) begin : g_pair
                if (j > k) begin : g_hi
                    assign kill[k*LANES+j] = en_raw[j] &&
                        (in_dest[j*REG_AW +: REG_AW] == in_dest[k*REG_AW +: REG_AW]);
                end else begin : g_lo
                    assign kill[k*LANES+j] = 1'b0;
                end
            end

            assign en_final[k] = en_raw[k] && !(|kill[k*LANES +: LANES]);
        end
    endgenerate

    // Valid/ready: a bundle moves in when in_valid && in_ready; presented
    // writes retire when rf_we != 0 && rf_ready, and hold stable otherwise.
    assign held       = |rf_we;
    assign in_ready   = !reset && (!held || rf_ready);
    assign accept     = in_valid && in_ready;
    assign commit     = held && rf_ready;
    assign retire_inc = 32'(popcount(MAX_LANES'(rf_we)));

    always_ff @(posedge clock2) begin
        if (reset) begin
            rf_we         <= '0;
            rf_waddr      <= '0;
            rf_wdata      <= '0;
            retired_count <= '0;
        end else begin
            if (accept) begin
                rf_we    <= en_final;
                rf_waddr <= in_dest;
                rf_wdata <= lane_data;
            end else if (commit) begin
                rf_we <= '0;
            end
            if (commit) begin
                retired_count <= retired_count + retire_inc;
            end
        end
    end

endmodule

// File: tb/tb_wb_stage_multi.sv
// Self-checking bench for wb_stage_multi: directed scenarios plus randomized
// traffic checked against a bundle-level reference model.
module tb_wb_stage_multi;

    localparam int LANES  = 3;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int BW     = LANES + REG_AW*LANES + DATA_W*LANES;

    logic                     clock2 = 1'b0;
    logic                     reset;
    logic                     in_valid;
    logic                     in_ready;
    logic [LANES-1:0]         in_wb_en;
    logic [LANES-1:0]         in_mem_read;
    logic [2*LANES-1:0]       in_load_size;
    logic [LANES-1:0]         in_load_signed;
    logic [2*LANES-1:0]       in_byte_off;
    logic [REG_AW*LANES-1:0] in_dest;
    logic [DATA_W*LANES-1:0] in_alu_result;
    logic [DATA_W*LANES-1:0] in_mem_data;
    logic [LANES-1:0]         rf_we;
    logic [REG_AW*LANES-1:0] rf_waddr;
    logic [DATA_W*LANES-1:0] rf_wdata;
    logic                     rf_ready;
    logic [31:0]              retired_count;

    int tests_run    = 0;
    int tests_failed = 0;

    // Scoreboard: expected output bundle after each edge, and model state.
    logic [BW-1:0]            exp_q[$];
    logic [LANES-1:0]         m_we;
    logic [REG_AW*LANES-1:0] m_waddr;
    logic [DATA_W*LANES-1:0] m_wdata;
    logic [31:0]              m_count;

    wb_stage_multi #(.LANES(LANES), .DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .clock2         (clock2),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_wb_en       (in_wb_en),
        .in_mem_read    (in_mem_read),
        .in_load_size   (in_load_size),
        .in_load_signed (in_load_signed),
        .in_byte_off    (in_byte_off),
        .in_dest        (in_dest),
        .in_alu_result  (in_alu_result),
        .in_mem_data    (in_mem_data),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .rf_ready       (rf_ready),
        .retired_count  (retired_count)
    );

    // ---------------- clock ----------------
    always #5 clock2 = ~clock2;

    // ---------------- reference model ----------------
    function automatic logic [31:0] load_val(input logic [31:0] mem, input logic [1:0] size,
                                             input logic sgn, input logic [1:0] off);
        logic [31:0] v;
        int sh;
        if (size == 2'd0) begin
            sh = 8 * int'(off);
            v = (mem >> sh) & 32'hFF;
            if (sgn && v >= 32'd128) v = v - 32'd256;
        end else if (size == 2'd1) begin
            sh = (off >= 2'd2) ? 16 : 0;
            v = (mem >> sh) & 32'hFFFF;
            if (sgn && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = mem;
        end
        return v;
    endfunction

    function automatic logic [BW-1:0] model_bundle();
        bit claimed[32];
        logic [LANES-1:0]         we;
        logic [DATA_W*LANES-1:0] data;
        logic [REG_AW-1:0]        d;
        we = '0;
        data = '0;
        for (int i = 0; i < 32; i++) claimed[i] = 0;
        for (int k = LANES-1; k >= 0; k--) begin
            d = in_dest[k*REG_AW +: REG_AW];
            if (in_wb_en[k] && d != 0 && !claimed[d]) begin
                we[k] = 1'b1;
                claimed[d] = 1;
            end
            if (in_mem_read[k])
                data[k*DATA_W +: DATA_W] = load_val(in_mem_data[k*DATA_W +: 32],
                    in_load_size[2*k +: 2], in_load_signed[k], in_byte_off[2*k +: 2]);
            else
                data[k*DATA_W +: DATA_W] = in_alu_result[k*DATA_W +: DATA_W];
        end
        return {we, in_dest, data};
    endfunction

    function automatic bit model_ready();
        return !reset && (m_we == 0 || rf_ready);
    endfunction

    function automatic logic [31:0] ones(input logic [LANES-1:0] v);
        logic [31:0] n;
        n = 0;
        for (int i = 0; i < LANES; i++) n = n + 32'(v[i]);
        return n;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        in_valid       = 1'b0;
        in_wb_en       = '0;
        in_mem_read    = '0;
        in_load_size   = '0;
        in_load_signed = '0;
        in_byte_off    = '0;
        in_dest        = '0;
        in_alu_result  = '0;
        in_mem_data    = '0;
    endtask

    task automatic set_lane(input int k, input logic en, input logic mr, input logic [1:0] sz,
                            input logic sg, input logic [1:0] off, input logic [REG_AW-1:0] d,
                            input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] mem);
        in_wb_en[k]                      = en;
        in_mem_read[k]                   = mr;
        in_load_size[2*k +: 2]           = sz;
        in_load_signed[k]                = sg;
        in_byte_off[2*k +: 2]            = off;
        in_dest[k*REG_AW +: REG_AW]      = d;
        in_alu_result[k*DATA_W +: DATA_W] = alu;
        in_mem_data[k*DATA_W +: DATA_W]   = mem;
    endtask

    task automatic randomize_inputs();
        in_valid = ($urandom_range(0, 3) != 0);
        for (int k = 0; k < LANES; k++) begin
            set_lane(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     2'($urandom_range(0, 3)), REG_AW'($urandom_range(0, 3)),
                     DATA_W'($urandom), DATA_W'($urandom));
        end
    endtask

    // Advance one clock: predict the post-edge outputs, then land on the next negedge.
    task automatic tick();
        logic [BW-1:0] nxt;
        if (reset) begin
            nxt = '0;
            m_count = 0;
        end else begin
            if (m_we != 0 && rf_ready) m_count = m_count + ones(m_we);
            if (in_valid && model_ready())
                nxt = model_bundle();
            else if (m_we != 0 && rf_ready)
                nxt = {{LANES{1'b0}}, m_waddr, m_wdata};
            else
                nxt = {m_we, m_waddr, m_wdata};
        end
        exp_q.push_back(nxt);
        @(posedge clock2);
        @(negedge clock2);
        nxt = exp_q.pop_front();
        {m_we, m_waddr, m_wdata} = nxt;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        rf_ready = 1'b1;
        clear_inputs();
        tick();
        tick();
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        tests_run++; if (rf_we !== '0) begin tests_failed++; $display("FAIL reset_rf_we: got %b expected 0", rf_we); end
        tests_run++; if (rf_waddr !== '0) begin tests_failed++; $display("FAIL reset_rf_waddr: got %h expected 0", rf_waddr); end
        tests_run++; if (rf_wdata !== '0) begin tests_failed++; $display("FAIL reset_rf_wdata: got %h expected 0", rf_wdata); end
        tests_run++; if (retired_count !== 32'd0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", retired_count); end
        reset = 1'b0;
        #1;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_alu_write();
        clear_inputs();
        rf_ready = 1'b1;
        in_valid = 1'b1;
        set_lane(0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 5'd1, 32'h15, 32'h0);
        set_lane(1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 5'd0, 32'h0, 32'h0);
        tick();
        in_valid = 1'b0;
        tests_run++; if (rf_we !== 3'b001) begin tests_failed++; $display("FAIL alu_we: got %b expected 001", rf_we); end
        tests_run++; if (rf_waddr[4:0] !== 5'd1) begin tests_failed++; $display("FAIL alu_waddr0: got %0d expected 1", rf_waddr[4:0]); end
        tests_run++; if (rf_wdata[31:0] !== 32'h15) begin tests_failed++; $display("FAIL alu_wdata0: got %h expected 15", rf_wdata[31:0]); end
        tick();
        tests_run++; if (retired_count !== 32'd1) begin tests_failed++; $display("FAIL alu_count: got %0d expected 1", retired_count); end
        tests_run++; if (rf_we !== 3'b000) begin tests_failed++; $display("FAIL alu_we_clear: got %b expected 000", rf_we); end
    endtask

    task automatic test_load_extract();
        logic [31:0] mems [7] = '{32'h0012_0000, 32'h0000_0080, 32'h0000_0080, 32'h0012_0000,
                                  32'hAB00_0000, 32'h0000_F234, 32'h8000_0000};
        logic [1:0]  szs  [7] = '{2'd1, 2'd0, 2'd0, 2'd2, 2'd0, 2'd1, 2'd3};
        logic        sgns [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [1:0]  offs [7] = '{2'd2, 2'd0, 2'd0, 2'd0, 2'd3, 2'd1, 2'd0};
        logic [31:0] exps [7] = '{32'h0000_0012, 32'hFFFF_FF80, 32'h0000_0080, 32'h0012_0000,
                                  32'hFFFF_FFAB, 32'h0000_F234, 32'h8000_0000};
        rf_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            clear_inputs();
            in_valid = 1'b1;
            set_lane(0, 1'b1, 1'b1, szs[i], sgns[i], offs[i], 5'd2, 32'hDEAD_BEEF, mems[i]);
            tick();
            in_valid = 1'b0;
            tests_run++;
            if (rf_wdata[31:0] !== exps[i]) begin
                tests_failed++;
                $display("FAIL load_%0d: got %h expected %h", i, rf_wdata[31:0], exps[i]);
            end
            tick();
        end
    endtask

    task automatic test_conflict_r0();
        logic [31:0] c0;
        rf_ready = 1'b1;
        c0 = m_count;
        clear_inputs();
        in_valid = 1'b1;
        set_lane(0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 5'd5, 32'd2, 32'd0);
        set_lane(1, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 5'd5, 32'd1, 32'd0);
        tick();
        tests_run++; if (rf_we !== 3'b010) begin tests_failed++; $display("FAIL conflict_we: got %b expected 010", rf_we); end
        tests_run++; if (rf_waddr[9:5] !== 5'd5) begin tests_failed++; $display("FAIL conflict_waddr1: got %0d expected 5", rf_waddr[9:5]); end
        tests_run++; if (rf_wdata[63:32] !== 32'd1) begin tests_failed++; $display("FAIL conflict_wdata1: got %h expected 1", rf_wdata[63:32]); end
        clear_inputs();
        in_valid = 1'b1;
        set_lane(0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 5'd0, 32'd8, 32'd0);
        tick();
        tests_run++; if (rf_we !== 3'b000) begin tests_failed++; $display("FAIL r0_we: got %b expected 000", rf_we); end
        in_valid = 1'b0;
        tick();
        tests_run++; if (retired_count !== c0 + 32'd1) begin tests_failed++; $display("FAIL r0_count: got %0d expected %0d", retired_count, c0 + 32'd1); end
        // Three lanes: disabled lane2 does not squash; lane2 beats lane0.
        clear_inputs();
        in_valid = 1'b1;
        set_lane(0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 5'd7, 32'd10, 32'd0);
        set_lane(1, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 5'd7, 32'd11, 32'd0);
        set_lane(2, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 5'd7, 32'd12, 32'd0);
        tick();
        tests_run++; if (rf_we !== 3'b010) begin tests_failed++; $display("FAIL conflict3a_we: got %b expected 010", rf_we); end
        clear_inputs();
        in_valid = 1'b1;
        set_lane(0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 5'd9, 32'd20, 32'd0);
        set_lane(1, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 5'd10, 32'd21, 32'd0);
        set_lane(2, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 5'd9, 32'd22, 32'd0);
        tick();
        in_valid = 1'b0;
        tests_run++; if (rf_we !== 3'b110) begin tests_failed++; $display("FAIL conflict3b_we: got %b expected 110", rf_we); end
        tests_run++; if (rf_wdata[95:64] !== 32'd22) begin tests_failed++; $display("FAIL conflict3b_wdata2: got %h expected 22", rf_wdata[95:64]); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] c0;
        c0 = m_count;
        clear_inputs();
        in_valid = 1'b1;
        rf_ready = 1'b0;
        set_lane(0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 5'd3, 32'd7, 32'd0);
        tick();
        clear_inputs();
        in_valid = 1'b1;
        set_lane(1, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 5'd4, 32'd9, 32'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_in_ready_%0d: got %b expected 0", i, in_ready); end
            tick();
            tests_run++; if (rf_we !== 3'b001) begin tests_failed++; $display("FAIL bp_we_%0d: got %b expected 001", i, rf_we); end
            tests_run++; if (rf_waddr[4:0] !== 5'd3 || rf_wdata[31:0] !== 32'd7) begin
                tests_failed++; $display("FAIL bp_data_%0d: got %0d/%h expected 3/7", i, rf_waddr[4:0], rf_wdata[31:0]);
            end
            tests_run++; if (retired_count !== c0) begin tests_failed++; $display("FAIL bp_count_%0d: got %0d expected %0d", i, retired_count, c0); end
        end
        rf_ready = 1'b1;
        #1;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        tests_run++; if (rf_we !== 3'b010 || rf_wdata[63:32] !== 32'd9) begin
            tests_failed++; $display("FAIL bp_next: got %b/%h expected 010/9", rf_we, rf_wdata[63:32]);
        end
        tests_run++; if (retired_count !== c0 + 32'd1) begin tests_failed++; $display("FAIL bp_commit_count: got %0d expected %0d", retired_count, c0 + 32'd1); end
        tick();
        tests_run++; if (retired_count !== c0 + 32'd2) begin tests_failed++; $display("FAIL bp_final_count: got %0d expected %0d", retired_count, c0 + 32'd2); end
    endtask

    task automatic test_reset_while_held();
        clear_inputs();
        in_valid = 1'b1;
        rf_ready = 1'b0;
        set_lane(0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 5'd6, 32'd4, 32'd0);
        tick();
        in_valid = 1'b0;
        tests_run++; if (rf_we !== 3'b001) begin tests_failed++; $display("FAIL rh_held: got %b expected 001", rf_we); end
        reset = 1'b1;
        tick();
        tests_run++; if (rf_we !== '0 || rf_waddr !== '0 || rf_wdata !== '0) begin
            tests_failed++; $display("FAIL rh_outputs: got %b/%h/%h expected zeros", rf_we, rf_waddr, rf_wdata);
        end
        tests_run++; if (retired_count !== 32'd0) begin tests_failed++; $display("FAIL rh_count: got %0d expected 0", retired_count); end
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL rh_in_ready: got %b expected 0", in_ready); end
        reset = 1'b0;
        rf_ready = 1'b1;
        tick();
        tests_run++; if (retired_count !== 32'd0) begin tests_failed++; $display("FAIL rh_count_after: got %0d expected 0", retired_count); end
    endtask

    task automatic test_counter_wrap();
        force dut.retired_count = 32'hFFFF_FFFF;
        #1;
        release dut.retired_count;
        m_count = 32'hFFFF_FFFF;
        tests_run++; if (retired_count !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL wrap_preload: got %h expected ffffffff", retired_count); end
        clear_inputs();
        in_valid = 1'b1;
        rf_ready = 1'b1;
        set_lane(2, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 5'd2, 32'd1, 32'd0);
        tick();
        in_valid = 1'b0;
        tick();
        tests_run++; if (retired_count !== 32'd0) begin tests_failed++; $display("FAIL wrap_count: got %h expected 0", retired_count); end
    endtask

    task automatic test_traffic(input int n, input bit always_ready);
        for (int c = 0; c < n; c++) begin
            randomize_inputs();
            if (always_ready) in_valid = 1'b1;
            rf_ready = always_ready ? 1'b1 : ($urandom_range(0, 9) < 7);
            #1;
            tests_run++;
            if (in_ready !== model_ready()) begin
                tests_failed++; $display("FAIL traffic_in_ready c%0d: got %b expected %b", c, in_ready, model_ready());
            end
            tick();
            tests_run++;
            if (rf_we !== m_we) begin
                tests_failed++; $display("FAIL traffic_we c%0d: got %b expected %b", c, rf_we, m_we);
            end
            for (int k = 0; k < LANES; k++) begin
                if (m_we[k]) begin
                    tests_run++;
                    if (rf_waddr[k*REG_AW +: REG_AW] !== m_waddr[k*REG_AW +: REG_AW] ||
                        rf_wdata[k*DATA_W +: DATA_W] !== m_wdata[k*DATA_W +: DATA_W]) begin
                        tests_failed++;
                        $display("FAIL traffic_lane%0d c%0d: got %0d/%h expected %0d/%h", k, c,
                                 rf_waddr[k*REG_AW +: REG_AW], rf_wdata[k*DATA_W +: DATA_W],
                                 m_waddr[k*REG_AW +: REG_AW], m_wdata[k*DATA_W +: DATA_W]);
                    end
                end
            end
            tests_run++;
            if (retired_count !== m_count) begin
                tests_failed++; $display("FAIL traffic_count c%0d: got %0d expected %0d", c, retired_count, m_count);
            end
        end
        clear_inputs();
        rf_ready = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        test_traffic(8, 1'b1);
    endtask

    task automatic test_random();
        test_traffic(400, 1'b0);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        m_we    = '0;
        m_waddr = '0;
        m_wdata = '0;
        m_count = '0;
        reset   = 1'b1;
        rf_ready = 1'b1;
        clear_inputs();
        @(negedge clock2);
        test_reset();
        test_alu_write();
        test_load_extract();
        test_conflict_r0();
        test_backpressure();
        test_reset_while_held();
        test_counter_wrap();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/wb_stage_multi.md
# wb_stage_multi

Parametrised multi-lane writeback stage at the end of the pipeline, after MEM, in front of the register file.
- Takes one bundle of up to LANES results per cycle.
- Per lane, selects the ALU result or an aligned, extended load value.
- Resolves same-destination conflicts inside a bundle and suppresses writes to r0.
- Presents registered write ports to the register file under a valid/ready handshake, and counts retired register writes.

## Interface
- LANES, default 2: number of result lanes and register-file write ports (1..4).
- DATA_W, default 32: datapath width; a multiple of 32.
- REG_AW, default 5: register address width.
- clock2  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  bundle present.
- in_ready  out  1  stage accepts the bundle this cycle.
- in_wb_en  in  LANES  per-lane register write request.
- in_mem_read  in  LANES  per-lane: 1 = load value, 0 = ALU result.
- in_load_size  in  2*LANES  per-lane: 0 byte, 1 half, 2 word, 3 treated as word.
- in_load_signed  in  LANES  per-lane: sign-extend (1) or zero-extend (0).
- in_byte_off  in  2*LANES  per-lane byte offset of the load within the low 32-bit word.
- in_dest  in  REG_AW*LANES  per-lane destination register.
- in_alu_result  in  DATA_W*LANES  per-lane ALU result.
- in_mem_data  in  DATA_W*LANES  per-lane raw memory word.
- rf_we  out  LANES  per-lane write enable; valid when set.
- rf_waddr  out  REG_AW*LANES  write addresses.
- rf_wdata  out  DATA_W*LANES  write data.
- rf_ready  in  1  register file accepts the presented writes this cycle.
- retired_count  out  32  total committed register writes.

## Operation
- Handshake: a bundle is accepted when in_valid && in_ready.
- in_ready = !reset && (!held || rf_ready). `held` means rf_we is non-zero and awaiting rf_ready.
- Lane data selection:
  - in_mem_read = 0 → the lane's ALU result, full width.
  - in_mem_read = 1 → load data extracted from the low 32 bits of in_mem_data.
- Load extraction:
  - Byte: bits [8*off+7 : 8*off].
  - Half: offset bit 0 ignored, bits [16*off[1]+15 : 16*off[1]].
  - Word: bits [31:0].
  - Each result is extended to DATA_W per in_load_signed.
- Lane enable: effective enable = in_wb_en[k] && in_dest[k] != 0.
- Conflict rule: if two enabled lanes share a destination, only the highest-index lane writes; lower lanes are cleared.
- Output register: on accept, rf_we/rf_waddr/rf_wdata load the processed bundle. A bundle with no effective enables loads rf_we = 0.
- Commit: when rf_we != 0 && rf_ready, retired_count += popcount(rf_we). The counter wraps modulo 2^32.
- No new accept in a cycle → rf_we clears after a commit; while not ready it holds, and all outputs stay stable.
- Simultaneous commit and accept in the same cycle: the new bundle replaces the old one with no bubble.

## Timing
- Reset values: rf_we = 0, rf_waddr = 0, rf_wdata = 0, retired_count = 0, in_ready = 0 while reset is high.
- Latency: a bundle accepted at edge N appears on the rf_* outputs after edge N (one cycle).
- Throughput: one bundle per cycle while rf_ready = 1.
- Backpressure: rf_ready low with rf_we != 0 drops in_ready combinationally in the same cycle. rf_ready has a combinational path to in_ready.
- Reset mid-hold: the held bundle is discarded, not committed, and not counted.
- The counter update and the output register update use the same edge.

## Structure
- Package wb_pkg:
  - Load-size constants LS_BYTE = 0, LS_HALF = 1, LS_WORD = 2.
  - Lane count limit MAX_LANES = 4.
- Sub-module wb_load_align: combinational; inputs raw word, size, signed, offset; output extended DATA_W value. Instantiated once per lane.
- Top-level content:
  - Lane mux.
  - Conflict-priority logic (generate loop over lane pairs).
  - Output register.
  - Retire counter.

## Test plan
- ALU writes: lane0 0x15 → r1 and lane1 0x0 with wb_en = 0 → next cycle rf_we = 01, waddr0 = 1, wdata0 = 0x15; retired_count = 1.
- Load extraction: mem_data 0x00120000 with signed half and off = 2 → 0x12. Signed byte 0x80 → 0xFFFFFF80. Unsigned byte 0x80 → 0x80. Word → 0x00120000.
- Dual lane plus r0: lane0 = 2 → r5, lane1 = 1 → r5 → only lane1 writes 1. A second bundle writing 8 → r0 gives rf_we = 0 and the count is unchanged.
- Backpressure: rf_ready low for 3 cycles with a bundle held → outputs stable and in_ready = 0. Release → commit counted once and the next bundle is accepted in the same cycle.
- Reset while held: assert reset while a bundle is held → all outputs are 0 next cycle and retired_count = 0.
- Counter wrap: preload via 2^32−1 commits, or a forced counter value under simulation → next single-lane commit gives 0.
